// File: rtl/pong_pkg.sv
// Shared constants for the pong game sequencer: screen/sprite geometry, pixel counts and FSM state codes.
package pong_pkg;

    localparam int SCR_W  = 160;
    localparam int SCR_H  = 120;
    localparam int PAD_W  = 2;
    localparam int PAD_H  = 16;
    localparam int BALL_W = 4;

    localparam int SCR_NPIX  = SCR_W * SCR_H;
    localparam int PAD_NPIX  = PAD_W * PAD_H;
    localparam int BALL_NPIX = BALL_W * BALL_W;

    // Pixel counter must hold a full-screen count (19200).
    localparam int CNT_W = 15;

    typedef logic [3:0] state_t;

    localparam state_t S_MENU      = 4'd0;
    localparam state_t S_WAIT      = 4'd1;
    localparam state_t S_SETUP_CLR = 4'd2;
    localparam state_t S_CLR       = 4'd3;
    localparam state_t S_MOVE      = 4'd4;
    localparam state_t S_SETUP_L   = 4'd5;
    localparam state_t S_DRAW_L    = 4'd6;
    localparam state_t S_SETUP_R   = 4'd7;
    localparam state_t S_DRAW_R    = 4'd8;
    localparam state_t S_SETUP_B   = 4'd9;
    localparam state_t S_DRAW_B    = 4'd10;
    localparam state_t S_OVER      = 4'd11;

endpackage

// File: rtl/frame_tick_gen.sv
// Frame pacing divider: counts 0..FRAME_DIV-1 and emits a one-cycle tick on the wrap; clr holds it at zero.
module frame_tick_gen #(
    parameter int FRAME_DIV = 833334
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int FW = $clog2(FRAME_DIV);

    logic [FW-1:0] fcnt;
    logic          at_wrap;

    assign at_wrap = (fcnt == FW'(FRAME_DIV - 1));
    assign tick    = !clr && at_wrap;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            fcnt <= '0;
        end else if (at_wrap) begin
            fcnt <= '0;
        end else begin
            fcnt <= fcnt + FW'(1);
        end
    end

endmodule

// File: rtl/pong_control.sv
// Pong game sequencer: frame pacing, per-frame datapath strobe order, VGA plot timing, menu/gameover flow.
// Optional build macro PONG_PAUSE_EN: pause freezes the game (MOVE skipped) while the screen keeps redrawing.
module pong_control
    import pong_pkg::*;
#(
    parameter int FRAME_DIV   = 833334,
    parameter int SCR_PIXELS  = SCR_NPIX,
    parameter int PAD_PIXELS  = PAD_NPIX,
    parameter int BALL_PIXELS = BALL_NPIX
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic pause,
    input  logic gameover,
    output logic set_up_clear_screen,
    output logic clear_screen,
    output logic move_pads,
    output logic move_ball,
    output logic set_up_left_pad,
    output logic draw_left_pad,
    output logic set_up_right_pad,
    output logic draw_right_pad,
    output logic set_up_ball,
    output logic draw_ball,
    output logic reset_delta,
    output logic menu,
    output logic plot
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last;
    logic             in_draw;
    logic             at_last;
    logic             tick;
    logic             frame_clr;
    logic             pending;
    logic             start_q;
    logic             skip_move;

    assign frame_clr = (state == S_MENU) || (state == S_OVER);

    frame_tick_gen #(
        .FRAME_DIV (FRAME_DIV)
    ) u_frame_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (frame_clr),
        .tick  (tick)
    );

`ifdef PONG_PAUSE_EN
    logic pause_q;

    // Pause is sampled while idle so a frame is either fully frozen or fully live.
    always_ff @(posedge clk) begin
        if (reset) begin
            pause_q <= 1'b0;
        end else if (state == S_WAIT) begin
            pause_q <= pause;
        end
    end

    assign skip_move = pause_q;
`else
    logic unused_pause;

    assign unused_pause = pause;
    assign skip_move    = 1'b0;
`endif

    // NOTE: combinational blocks assign a default first so no path leaves a value held (no latch).
    always_comb begin
        last = '0;
        case (state)
            S_CLR:              last = CNT_W'(SCR_PIXELS);
            S_DRAW_L, S_DRAW_R: last = CNT_W'(PAD_PIXELS);
            S_DRAW_B:           last = CNT_W'(BALL_PIXELS);
            default:            last = '0;
        endcase
    end

    assign in_draw = (state == S_CLR) || (state == S_DRAW_L) ||
                     (state == S_DRAW_R) || (state == S_DRAW_B);
    assign at_last = in_draw && (cnt == last);

    always_comb begin
        state_nxt = state;
        case (state)
            S_MENU:      if (start) state_nxt = S_WAIT;
            S_WAIT:      if (tick || pending) state_nxt = S_SETUP_CLR;
            S_SETUP_CLR: state_nxt = S_CLR;
            S_CLR:       if (at_last) state_nxt = skip_move ? S_SETUP_L : S_MOVE;
            S_MOVE:      state_nxt = S_SETUP_L;
            S_SETUP_L:   state_nxt = S_DRAW_L;
            S_DRAW_L:    if (at_last) state_nxt = S_SETUP_R;
            S_SETUP_R:   state_nxt = S_DRAW_R;
            S_DRAW_R:    if (at_last) state_nxt = S_SETUP_B;
            S_SETUP_B:   state_nxt = S_DRAW_B;
            S_DRAW_B:    if (at_last) state_nxt = gameover ? S_OVER : S_WAIT;
            S_OVER:      if (start && !start_q) state_nxt = S_MENU;
            default:     state_nxt = S_MENU;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_MENU;
            cnt     <= '0;
            pending <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            start_q <= start;

            if (in_draw && !at_last) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end

            // A tick during the draw sequence is remembered once; WAIT consumes it.
            if (frame_clr || state == S_WAIT) begin
                pending <= 1'b0;
            end else if (tick) begin
                pending <= 1'b1;
            end
        end
    end

    assign menu                = (state == S_MENU);
    assign set_up_clear_screen = (state == S_SETUP_CLR);
    assign clear_screen        = (state == S_CLR);
    assign move_pads           = (state == S_MOVE);
    assign move_ball           = (state == S_MOVE);
    assign set_up_left_pad     = (state == S_SETUP_L);
    assign draw_left_pad       = (state == S_DRAW_L);
    assign set_up_right_pad    = (state == S_SETUP_R);
    assign draw_right_pad      = (state == S_DRAW_R);
    assign set_up_ball         = (state == S_SETUP_B);
    assign draw_ball           = (state == S_DRAW_B);
    assign reset_delta         = set_up_clear_screen || set_up_left_pad ||
                                 set_up_right_pad || set_up_ball;

    // Datapath x/y lag the strobe by one cycle, so the first strobe cycle never writes.
    assign plot = in_draw && (cnt != '0);

endmodule

// File: tb/tb_pong_control.sv
// Directed self-checking bench for pong_control; expectations adapt to the PONG_PAUSE_EN build option.
module tb_pong_control;

    localparam int FRAME_DIV  = 20000;
    localparam int SCR_N      = 19200;
    localparam int PAD_N      = 32;
    localparam int BALL_N     = 16;
    localparam int WAIT_LIMIT = 21000;
    localparam int SCAN_LIMIT = 20000;
    localparam logic [12:0] MENU_OUTS = 13'b0000000000010;

`ifdef PONG_PAUSE_EN
    localparam int PAUSED_MOVES = 0;
`else
    localparam int PAUSED_MOVES = 1;
`endif

    logic clk = 1'b0;
    logic reset, start, pause, gameover;
    logic set_up_clear_screen, clear_screen, move_pads, move_ball;
    logic set_up_left_pad, draw_left_pad, set_up_right_pad, draw_right_pad;
    logic set_up_ball, draw_ball, reset_delta, menu, plot;
    logic [12:0] outs;

    assign outs = {set_up_clear_screen, clear_screen, move_pads, move_ball,
                   set_up_left_pad, draw_left_pad, set_up_right_pad, draw_right_pad,
                   set_up_ball, draw_ball, reset_delta, menu, plot};

    int n_checks = 0;
    int n_errors = 0;

    int n_pc, n_pl, n_pr, n_pb, n_plot, n_stray;
    int n_clr, n_l, n_r, n_b;
    int n_move, n_move_any, move_order_err, setup_err, n_setup, n_rd, idle_busy;
    logic [12:0] rst_outs;

    pong_control #(
        .FRAME_DIV   (FRAME_DIV),
        .SCR_PIXELS  (SCR_N),
        .PAD_PIXELS  (PAD_N),
        .BALL_PIXELS (BALL_N)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .pause               (pause),
        .gameover            (gameover),
        .set_up_clear_screen (set_up_clear_screen),
        .clear_screen        (clear_screen),
        .move_pads           (move_pads),
        .move_ball           (move_ball),
        .set_up_left_pad     (set_up_left_pad),
        .draw_left_pad       (draw_left_pad),
        .set_up_right_pad    (set_up_right_pad),
        .draw_right_pad      (draw_right_pad),
        .set_up_ball         (set_up_ball),
        .draw_ball           (draw_ball),
        .reset_delta         (reset_delta),
        .menu                (menu),
        .plot                (plot)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for the next frame, then tallies strobes and plots cycle by cycle until draw_ball falls,
    // or optionally fires reset on the draw_right_pad cycle with cnt=10.
    task automatic watch_frame(input bit inject_reset, output int wait_cycles);
        logic p_clr, p_l, p_r, p_b, p_su_clr, p_su_l, p_su_r, p_su_b, p_rd;
        bit done;
        n_pc = 0; n_pl = 0; n_pr = 0; n_pb = 0; n_plot = 0; n_stray = 0;
        n_clr = 0; n_l = 0; n_r = 0; n_b = 0;
        n_move = 0; n_move_any = 0; move_order_err = 0; setup_err = 0;
        n_setup = 0; n_rd = 0; idle_busy = 0;
        rst_outs = '1;
        wait_cycles = 0;
        while (!set_up_clear_screen && wait_cycles < WAIT_LIMIT) begin
            if (outs != 13'd0) idle_busy++;
            step();
            wait_cycles++;
        end
        {p_clr, p_l, p_r, p_b, p_su_clr, p_su_l, p_su_r, p_su_b, p_rd} = '0;
        done = 1'b0;
        for (int c = 0; c < SCAN_LIMIT && !done; c++) begin
            if (set_up_clear_screen || set_up_left_pad || set_up_right_pad || set_up_ball) n_setup++;
            if (reset_delta)    n_rd++;
            if (clear_screen)   n_clr++;
            if (draw_left_pad)  n_l++;
            if (draw_right_pad) n_r++;
            if (draw_ball)      n_b++;
            if (plot) begin
                n_plot++;
                if (clear_screen)        n_pc++;
                else if (draw_left_pad)  n_pl++;
                else if (draw_right_pad) n_pr++;
                else if (draw_ball)      n_pb++;
                else                     n_stray++;
            end
            if (move_pads && move_ball) n_move++;
            if (move_pads || move_ball) begin
                n_move_any++;
                if (n_clr != SCR_N + 1 || n_l != 0) move_order_err++;
            end
            if (clear_screen && !p_clr && (plot || !(p_su_clr && p_rd))) setup_err++;
            if (draw_left_pad && !p_l && (plot || !(p_su_l && p_rd)))    setup_err++;
            if (draw_right_pad && !p_r && (plot || !(p_su_r && p_rd)))   setup_err++;
            if (draw_ball && !p_b && (plot || !(p_su_b && p_rd)))        setup_err++;

            if (inject_reset && draw_right_pad && n_r == 11) begin
                reset = 1'b1;
                step();
                rst_outs = outs;
                reset = 1'b0;
                done = 1'b1;
            end else if (p_b && !draw_ball) begin
                done = 1'b1;
            end else begin
                p_clr = clear_screen; p_l = draw_left_pad; p_r = draw_right_pad; p_b = draw_ball;
                p_su_clr = set_up_clear_screen; p_su_l = set_up_left_pad;
                p_su_r = set_up_right_pad; p_su_b = set_up_ball; p_rd = reset_delta;
                step();
            end
        end
    endtask

    initial begin
        int w;
        int over_busy;
        reset = 1'b1; start = 1'b0; pause = 1'b0; gameover = 1'b0;
        repeat (3) step();
        check("reset_outs", 32'(outs), 32'(MENU_OUTS));
        reset = 1'b0;
        step();
        step();
        check("menu_idle", 32'(outs), 32'(MENU_OUTS));

        // start stays high through the whole first frame; it must be ignored outside MENU/OVER.
        start = 1'b1;
        step();
        check("start_to_wait", 32'(outs), 0);

        watch_frame(1'b1, w);
        check("f1_latency", w, FRAME_DIV);
        check("f1_wait_quiet", idle_busy, 0);
        check("f1_clr_len", n_clr, SCR_N + 1);
        check("f1_clr_plots", n_pc, SCR_N);
        check("f1_move", n_move, 1);
        check("f1_move_any", n_move_any, 1);
        check("f1_move_order", move_order_err, 0);
        check("f1_left_len", n_l, PAD_N + 1);
        check("f1_left_plots", n_pl, PAD_N);
        check("f1_right_plots_at_rst", n_pr, 10);
        check("f1_setup_err", setup_err, 0);
        check("f1_setups", n_setup, 3);
        check("f1_reset_delta", n_rd, 3);
        check("f1_stray_plot", n_stray, 0);
        check("mid_draw_reset_outs", 32'(rst_outs), 32'(MENU_OUTS));

        // start is still high, so release of reset re-enters WAIT one cycle later.
        pause = 1'b1;
        gameover = 1'b1;
        watch_frame(1'b0, w);
        check("f2_latency", w, FRAME_DIV + 1);
        check("f2_clr_plots", n_pc, SCR_N);
        check("f2_left_plots", n_pl, PAD_N);
        check("f2_right_len", n_r, PAD_N + 1);
        check("f2_right_plots", n_pr, PAD_N);
        check("f2_ball_len", n_b, BALL_N + 1);
        check("f2_ball_plots", n_pb, BALL_N);
        check("f2_total_plots", n_plot, SCR_N + 2 * PAD_N + BALL_N);
        check("f2_paused_moves", n_move_any, PAUSED_MOVES);
        check("f2_setup_err", setup_err, 0);
        check("f2_setups", n_setup, 4);
        check("f2_stray_plot", n_stray, 0);

        // In OVER with start held high: no edge, so nothing may happen.
        over_busy = 0;
        for (int i = 0; i < 500; i++) begin
            if (outs != 13'd0) over_busy++;
            step();
        end
        check("over_quiet", over_busy, 0);

        start = 1'b0;
        step();
        check("over_start_low", 32'(outs), 0);
        start = 1'b1;
        step();
        check("over_to_menu", 32'(outs), 32'(MENU_OUTS));
        step();
        check("menu_to_wait", 32'(outs), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
